// File: rtl/baud_tick_gen.sv
// Baud-rate tick generator for a UART.
// Produces an oversampled sample tick, a bit-rate tick and a bit-centre tick
// from clk_i. The divisor comes from elaboration-time presets or from a
// loadable custom register. Any divisor change, a low enable or a reset
// restarts the bit cleanly, so no partial bit period is ever emitted.
module baud_tick_gen #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             enable_i,
   input  logic [1:0]       baud_sel_i,
   input  logic [DIV_W-1:0] custom_div_i,
   input  logic             custom_load_i,
   output logic             sample_tick_o,
   output logic             bit_tick_o,
   output logic             mid_tick_o,
   output logic [DIV_W-1:0] div_active_o
);

   localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

   function automatic int round_div(input int num, input int den);
      return (num + den / 2) / den;
   endfunction

   localparam logic [DIV_W-1:0] DIV_2400   = DIV_W'(round_div(CLK_HZ, 2400 * OVERSAMPLE));
   localparam logic [DIV_W-1:0] DIV_4800   = DIV_W'(round_div(CLK_HZ, 4800 * OVERSAMPLE));
   localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(round_div(CLK_HZ, 9600 * OVERSAMPLE));
   localparam logic [DIV_W-1:0] CUSTOM_MIN = DIV_W'(2);
   localparam logic [OS_W-1:0]  OS_LAST    = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]  OS_MID     = OS_W'(OVERSAMPLE / 2 - 1);

   logic [DIV_W-1:0] custom_q, custom_d;
   logic [DIV_W-1:0] div_active_q, div_active_d;
   logic [DIV_W-1:0] smp_cnt_q, smp_cnt_d;
   logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
   logic [1:0]       baud_sel_q;
   logic             run_q;
   logic             sample_tick_q, sample_tick_d;
   logic             bit_tick_q, bit_tick_d;
   logic             mid_tick_q, mid_tick_d;
   logic             div_change;
   logic             clear;
   logic [DIV_W-1:0] div_last;

   // Custom divisor capture; 0 and 1 cannot produce a tick pattern, so clamp to 2.
   always_comb begin
      custom_d = custom_q;
      if (custom_load_i) begin
         custom_d = (custom_div_i < CUSTOM_MIN) ? CUSTOM_MIN : custom_div_i;
      end
   end

   // Divisor selection; custom path uses the value being captured this cycle.
   always_comb begin
      case (baud_sel_i)
         2'b00:   div_active_d = DIV_2400;
         2'b01:   div_active_d = DIV_4800;
         2'b10:   div_active_d = DIV_9600;
         default: div_active_d = custom_d;
      endcase
   end

   // Restart conditions: divisor change, enable low, or first cycle after
   // enable/reset release (run_q low), so every restart spans a full period.
   assign div_change = (baud_sel_i != baud_sel_q) ||
                       (custom_load_i && (baud_sel_i == 2'b11));
   assign clear      = div_change || !enable_i || !run_q;
   assign div_last   = div_active_q - DIV_W'(1);

   // Counter and tick next-state; ticks are high while the sample counter sits at div-1.
   always_comb begin
      smp_cnt_d     = smp_cnt_q;
      os_cnt_d      = os_cnt_q;
      sample_tick_d = 1'b0;
      bit_tick_d    = 1'b0;
      mid_tick_d    = 1'b0;
      if (clear) begin
         smp_cnt_d = '0;
         os_cnt_d  = '0;
      end else begin
         if (smp_cnt_q == div_last) begin
            smp_cnt_d = '0;
         end else begin
            smp_cnt_d = smp_cnt_q + DIV_W'(1);
         end
         if (smp_cnt_d == div_last) begin
            sample_tick_d = 1'b1;
            bit_tick_d    = (os_cnt_q == OS_LAST);
            mid_tick_d    = (os_cnt_q == OS_MID);
            os_cnt_d      = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
         end
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         custom_q      <= CUSTOM_MIN;
         div_active_q  <= DIV_2400;
         smp_cnt_q     <= '0;
         os_cnt_q      <= '0;
         baud_sel_q    <= 2'b00;
         run_q         <= 1'b0;
         sample_tick_q <= 1'b0;
         bit_tick_q    <= 1'b0;
         mid_tick_q    <= 1'b0;
      end else begin
         custom_q      <= custom_d;
         div_active_q  <= div_active_d;
         smp_cnt_q     <= smp_cnt_d;
         os_cnt_q      <= os_cnt_d;
         baud_sel_q    <= baud_sel_i;
         run_q         <= enable_i;
         sample_tick_q <= sample_tick_d;
         bit_tick_q    <= bit_tick_d;
         mid_tick_q    <= mid_tick_d;
      end
   end

   assign sample_tick_o = sample_tick_q;
   assign bit_tick_o    = bit_tick_q;
   assign mid_tick_o    = mid_tick_q;
   assign div_active_o  = div_active_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen at 50 MHz, 16x oversampling.
module tb_baud_tick_gen;

   localparam int DIV_W = 16;

   logic             clk_sys = 1'b0;
   logic             rst_n;
   logic             enable;
   logic [1:0]       baud_sel;
   logic [DIV_W-1:0] custom_div;
   logic             custom_load;
   logic             sample_tick;
   logic             bit_tick;
   logic             mid_tick;
   logic [DIV_W-1:0] div_active;

   int cyc      = 0;
   int n_checks = 0;
   int n_fail   = 0;

   baud_tick_gen #(
      .CLK_HZ    (50_000_000),
      .OVERSAMPLE(16),
      .DIV_W     (DIV_W)
   ) dut (
      .clk_i        (clk_sys),
      .rst_n_i      (rst_n),
      .enable_i     (enable),
      .baud_sel_i   (baud_sel),
      .custom_div_i (custom_div),
      .custom_load_i(custom_load),
      .sample_tick_o(sample_tick),
      .bit_tick_o   (bit_tick),
      .mid_tick_o   (mid_tick),
      .div_active_o (div_active)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // which: 0 = sample, 1 = bit, 2 = mid. Returns cycle stamp, or -1 on timeout.
   task automatic wait_tick(input int which, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget && at < 0; i++) begin
         @(negedge clk_sys);
         if ((which == 0 && sample_tick) || (which == 1 && bit_tick) ||
             (which == 2 && mid_tick))
            at = cyc;
      end
   endtask

   initial begin
      int n, t, at, cnt;
      rst_n       = 1'b0;
      enable      = 1'b1;
      baud_sel    = 2'b10;
      custom_div  = '0;
      custom_load = 1'b0;

      // reset state and 9600 baud timing
      repeat (3) @(negedge clk_sys);
      check("rst_sample", int'(sample_tick), 0);
      check("rst_bit", int'(bit_tick), 0);
      check("rst_mid", int'(mid_tick), 0);
      n = cyc;
      rst_n = 1'b1;
      @(negedge clk_sys);
      check("div_9600", int'(div_active), 326);
      wait_tick(0, 400, at);
      check("first_sample_9600", at, n + 326);
      t = at;
      wait_tick(0, 400, at);
      check("sample_period_9600", at - t, 326);
      wait_tick(2, 6000, at);
      check("mid_first_9600", at, n + 2608);
      wait_tick(1, 6000, at);
      check("bit_first_9600", at, n + 5216);
      check("bit_with_sample", int'(sample_tick), 1);
      t = at;
      wait_tick(2, 6000, at);
      check("mid_after_bit", at - t, 2608);
      wait_tick(1, 6000, at);
      check("bit_period_9600", at - t, 5216);

      // custom divisor 3
      baud_sel    = 2'b11;
      custom_div  = 16'd3;
      custom_load = 1'b1;
      n = cyc;
      @(negedge clk_sys);
      custom_load = 1'b0;
      check("chg_cycle_quiet", int'(sample_tick | bit_tick | mid_tick), 0);
      check("div_custom3", int'(div_active), 3);
      wait_tick(0, 10, at);
      check("first_sample_c3", at, n + 3);
      t = at;
      wait_tick(0, 10, at);
      check("sample_period_c3", at - t, 3);
      wait_tick(1, 100, at);
      check("bit_first_c3", at, n + 48);
      t = at;
      wait_tick(1, 100, at);
      check("bit_period_c3", at - t, 48);

      // clamp of 0 and 1
      for (int v = 0; v < 2; v++) begin
         custom_div  = DIV_W'(v);
         custom_load = 1'b1;
         n = cyc;
         @(negedge clk_sys);
         custom_load = 1'b0;
         check("div_clamp", int'(div_active), 2);
         wait_tick(0, 10, at);
         check("first_sample_clamp", at, n + 2);
         t = at;
         wait_tick(0, 10, at);
         check("sample_period_clamp", at - t, 2);
      end

      // 2400 then switch to 4800 mid-bit
      baud_sel = 2'b00;
      @(negedge clk_sys);
      check("div_2400", int'(div_active), 1302);
      repeat (2999) @(negedge clk_sys);
      baud_sel = 2'b01;
      n = cyc;
      @(negedge clk_sys);
      check("sel_chg_quiet", int'(sample_tick | bit_tick | mid_tick), 0);
      check("div_4800", int'(div_active), 651);
      wait_tick(0, 1000, at);
      check("first_sample_4800", at, n + 651);
      wait_tick(1, 11000, at);
      check("bit_after_change", at, n + 10416);

      // enable dropped for 100 cycles mid-bit
      repeat (1000) @(negedge clk_sys);
      enable = 1'b0;
      cnt = 0;
      repeat (100) begin
         @(negedge clk_sys);
         if (sample_tick || bit_tick || mid_tick) cnt++;
      end
      check("no_tick_disabled", cnt, 0);
      enable = 1'b1;
      n = cyc;
      wait_tick(0, 1000, at);
      check("first_sample_reenable", at, n + 651);
      wait_tick(2, 6000, at);
      check("mid_after_reenable", at, n + 5208);

      // custom load with preset selected: captured but no restart
      baud_sel    = 2'b10;
      custom_div  = 16'd7;
      custom_load = 1'b1;
      n = cyc;
      @(negedge clk_sys);
      custom_load = 1'b0;
      check("div_load_ignored", int'(div_active), 326);
      wait_tick(0, 400, at);
      check("first_sample_9600b", at, n + 326);

      // asynchronous reset pulse between edges while a tick is high
      #1 rst_n = 1'b0;
      #1 check("async_rst_sample", int'(sample_tick), 0);
      n = cyc;
      #1 rst_n = 1'b1;
      wait_tick(0, 400, at);
      check("first_sample_after_rst", at, n + 326);
      baud_sel = 2'b11;
      @(negedge clk_sys);
      check("custom_reset_val", int'(div_active), 2);

      // load honoured with enable low
      enable      = 1'b0;
      custom_div  = 16'd4;
      custom_load = 1'b1;
      @(negedge clk_sys);
      custom_load = 1'b0;
      check("div_load_disabled", int'(div_active), 4);
      check("disabled_quiet", int'(sample_tick), 0);
      enable = 1'b1;
      n = cyc;
      wait_tick(0, 10, at);
      check("first_sample_c4", at, n + 4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit; legal values 4, 8 or 16.
REQ-003 SHALL have parameter DIV_W, default 16, width of the divisor path.
REQ-004 Clock  input  1  system clock; all state updates on rising edge.
REQ-005 ResetN  input  1  reset: one clock; reset is asynchronous and active-low.
REQ-006 Enable  input  1  high = generator runs; low = synchronous hold-clear.
REQ-007 BaudSel  input  2  00 = 2400, 01 = 4800, 10 = 9600, 11 = custom divisor.
REQ-008 CustomDiv  input  DIV_W  custom sample divisor, captured on CustomLoad.
REQ-009 CustomLoad  input  1  single-cycle strobe that captures CustomDiv.
REQ-010 SampleTick  output  1  one-cycle pulse at OVERSAMPLE x baud rate.
REQ-011 BitTick  output  1  one-cycle pulse at baud rate.
REQ-012 MidTick  output  1  one-cycle pulse at bit centre, for RX sampling.
REQ-013 DivActive  output  DIV_W  divisor currently in use.

Function
REQ-014 Preset divisors SHALL be computed at elaboration as round(CLK_HZ / (baud x OVERSAMPLE)).
- Defaults give 2400 -> 1302, 4800 -> 651, 9600 -> 326.
REQ-015 Custom register SHALL load CustomDiv on CustomLoad.
- CustomLoad is honoured regardless of Enable.
- Values 0 or 1 are clamped to 2.
REQ-016 DivActive SHALL be registered: preset for BaudSel 00/01/10, custom register for 11.
REQ-017 Sample counter SHALL count 0..DivActive-1 while Enable is high; SampleTick = 1 in the cycle the counter equals DivActive-1, then the counter wraps to 0.
REQ-018 Oversample counter (log2 OVERSAMPLE bits) SHALL increment on each SampleTick and wrap at OVERSAMPLE-1.
REQ-019 BitTick SHALL coincide with the SampleTick on which the oversample counter wraps, i.e. once per OVERSAMPLE sample ticks.
REQ-020 MidTick SHALL coincide with the SampleTick on which the oversample counter equals OVERSAMPLE/2-1.
REQ-021 On any change of the selected divisor (BaudSel change, or CustomLoad while BaudSel = 11), both counters SHALL clear to 0 on the next edge.
- All ticks are 0 in that cycle.
- First SampleTick follows DivActive cycles later (restart, no partial bit).
REQ-022 Enable low SHALL clear both counters synchronously and force all ticks to 0.
- First SampleTick occurs on the DivActive-th cycle after Enable returns high.
REQ-023 Divisor change and Enable low in the same cycle: clear takes priority; no tick.
REQ-024 At most one each of SampleTick, MidTick and BitTick SHALL be high per cycle.
- All ticks SHALL be registered outputs, free of glitches.

Reset
REQ-025 ResetN low SHALL asynchronously set:
- counters = 0
- SampleTick = BitTick = MidTick = 0
- custom register = 2
- DivActive = preset for current BaudSel, applied on the first edge after release.
REQ-026 Reset asserted mid-bit SHALL abort the bit; no tick SHALL be emitted until a full DivActive period after release.

Verification (CLK_HZ = 50_000_000, OVERSAMPLE = 16)
REQ-027 BaudSel = 10, Enable = 1 -> SampleTick period 326 cycles, BitTick period 5216 cycles, MidTick 2608 cycles after each BitTick.
REQ-028 BaudSel = 11, CustomDiv = 3 with CustomLoad -> counters restart; SampleTick every 3 cycles, BitTick every 48; DivActive = 3.
REQ-029 CustomDiv = 0 and 1 loaded with BaudSel = 11 -> DivActive = 2, SampleTick every 2 cycles.
REQ-030 BaudSel 00 -> 01 mid-bit -> no tick on the change cycle; next SampleTick 651 cycles later; BitTick 10416 cycles after the change.
REQ-031 Enable dropped for 100 cycles mid-bit -> no ticks while low; first SampleTick exactly DivActive cycles after re-enable.
REQ-032 ResetN pulsed low between clock edges mid-bit -> outputs 0 immediately; first SampleTick DivActive cycles after release.
